// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch/decode types and occupancy states for the IF/ID queue.
package fetch_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_state_t;
endpackage

// File: rtl/ifq_ptr_ctr.sv
// ifq_ptr_ctr: wrapping queue pointer with clear and increment; clear has priority.
module ifq_ptr_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_ptr
);
  logic [W-1:0] r_ptr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_ptr <= '0;
    else if (i_clr) r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + 1'b1;
  assign o_ptr = r_ptr;
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: in-order decoupling FIFO between fetch and decode, flushed on redirect.
// Optional IFQ_BYPASS_EN: an empty queue forwards the incoming entry to decode combinationally.
module if_id_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = fetch_pkg::XLEN,
  parameter int ILEN  = fetch_pkg::ILEN
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [ILEN-1:0]            in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ILEN-1:0]            out_instr,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  fetch_entry_t  r_mem [DEPTH];
  occ_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [AW-1:0] w_rd_ptr, w_wr_ptr;
  logic          w_enq, w_deq, w_wr, w_rd, w_byp;
  fetch_entry_t  w_head;
`ifdef IFQ_BYPASS_EN
  assign w_byp     = (r_state == OCC_EMPTY) & in_valid & ~flush;
  assign out_valid = (r_state != OCC_EMPTY) | w_byp;
  assign out_pc    = w_byp ? in_pc : w_head.pc;
  assign out_instr = w_byp ? in_instr : w_head.instr;
`else
  assign w_byp     = 1'b0;
  assign out_valid = r_state != OCC_EMPTY;
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;
`endif
  assign in_ready = r_state != OCC_FULL;
  assign count    = r_count;
  assign w_head   = r_mem[w_rd_ptr];
  assign w_enq    = in_valid & in_ready & ~flush;
  assign w_deq    = out_valid & out_ready & ~flush;
  // a bypassed entry consumed this cycle never touches storage
  assign w_wr     = w_enq & ~(w_byp & out_ready);
  assign w_rd     = w_deq & ~w_byp;
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = flush ? '0 : r_count + CW'(w_wr) - CW'(w_rd);
    if (flush) w_state_nxt = OCC_EMPTY;
    else
      case (r_state)
        OCC_EMPTY:   w_state_nxt = w_wr ? OCC_PARTIAL : OCC_EMPTY;
        OCC_PARTIAL: w_state_nxt = (w_wr & ~w_rd & (r_count == FULL_CNT - 1'b1)) ? OCC_FULL :
                                   (w_rd & ~w_wr & (r_count == CW'(1))) ? OCC_EMPTY : OCC_PARTIAL;
        OCC_FULL:    w_state_nxt = w_rd ? OCC_PARTIAL : OCC_FULL;
        default:     w_state_nxt = OCC_EMPTY;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= OCC_EMPTY;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    else if (w_wr) r_mem[w_wr_ptr] <= '{pc: in_pc, instr: in_instr};
  ifq_ptr_ctr #(.W(AW)) u_rd_ptr (
    .clk(clk), .reset_n(reset_n), .i_inc(w_rd), .i_clr(flush), .o_ptr(w_rd_ptr)
  );
  ifq_ptr_ctr #(.W(AW)) u_wr_ptr (
    .clk(clk), .reset_n(reset_n), .i_inc(w_wr), .i_clr(flush), .o_ptr(w_wr_ptr)
  );
endmodule
